absdiff_arbiter: RTL and testbench
==================================

Name: absdiff_arbiter

Overview:
- Shares one registered absolute-difference unit between NUM_REQ requesters.
- Each requester offers an operand pair (a, b) over a valid/ready handshake.
- A round-robin arbiter grants one pair at a time and sequences it through the unit.
- The result is returned on a single valid/ready output port, tagged with the requester ID, and completed operations are counted.

Parameters:
- NUM_REQ, 4, number of requesters; power of two, 2..16.
- DATA_W, 8, operand width (unsigned).
- CNT_W, 16, width of the completed-operation counter.
- Derived localparams: ID_W = clog2(NUM_REQ); RES_W = DATA_W+1.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*DATA_W  packed operand a; requester i at [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  packed operand b, same packing.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accept.
- res_data  out  RES_W  |a-b|, zero-extended; MSB always 0.
- res_id  out  ID_W  index of the requester that owns res_data.
- busy  out  1  high in any state except IDLE.
- done_cnt  out  CNT_W  number of results accepted downstream.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, rr_ptr=0, res_valid=0, res_data=0, res_id=0, done_cnt=0, req_ready=0.
  - Any in-flight operation is dropped. Reset wins over every other event in the same cycle.
- Handshakes:
  - Request transfer occurs when req_valid[i] & req_ready[i] are both high at a clock edge.
  - Result transfer occurs when res_valid & res_ready are both high at a clock edge.
- Arbitration is combinational round-robin:
  - Search starts at rr_ptr and proceeds rr_ptr, rr_ptr+1, … wrapping modulo NUM_REQ.
  - The first index with req_valid set is the winner.
  - req_ready is asserted for the winner only, and only in a grant-capable cycle (see states).
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- State machine:
  - IDLE:
    - Grant-capable. If any req_valid is set: latch winner's a, b and ID into the operand register, set rr_ptr = winner+1 (mod NUM_REQ), go CALC.
    - Otherwise stay in IDLE.
  - CALC:
    - No grant. The unit computes (a>b) ? a-b : b-a into the result register, stored with the latched ID.
    - Next state is OUT with res_valid=1.
    - Exactly one cycle.
  - OUT:
    - res_valid=1. res_data and res_id are held stable until transfer.
    - On transfer: done_cnt increments, wrapping at 2^CNT_W - 1 → 0.
    - Grant-capable only in the cycle res_ready=1. If a request wins in that cycle, latch it and go CALC (back-to-back). Otherwise go IDLE with res_valid=0.
    - If res_ready=0: no grant, stay in OUT. Requester inputs are not sampled.
- Timing:
  - Latency from request transfer to res_valid is 2 edges.
  - Sustained throughput is one result per 2 cycles with res_ready held at 1.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.
- Boundary conditions:
  - a==b → res_data=0.
  - a=0, b=2^DATA_W-1 → res_data = 2^DATA_W-1.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Withdrawing req_valid before a grant is allowed; the request is simply not serviced.
  - req_valid=0 everywhere while in OUT has no effect on the held result.
  - rst during OUT: res_valid drops the next cycle and the result is lost.

Decomposition:
- Package absdiff_pkg holds:
  - state enum {IDLE, CALC, OUT} (2-bit);
  - default DATA_W/NUM_REQ/CNT_W constants;
  - a function abs_diff(a, b) returning RES_W bits.
- One sub-module, absdiff_unit: registered |a-b| with load enable and synchronous clear, plus an ID passthrough register.
- The arbiter (rr search plus pointer) stays inline.

Test Plan:
- Single requester 0, a=0xAA, b=0x55, res_ready=1:
  - req_ready[0] is high in the same cycle;
  - res_valid is high 2 edges later with res_data=0x055, res_id=0;
  - done_cnt=1.
- Requester 2, a=0x0A, b=0xD5 → res_data=0x0CB, res_id=2. Then a=0xFA, b=0xFA → res_data=0x000.
- All 4 requesters held valid, res_ready=1, 8 operations:
  - grant order is 0,1,2,3,0,1,2,3;
  - results arrive every 2 cycles;
  - done_cnt=8.
- Backpressure:
  - Requester 1 sends a=0xFA, b=0x54 with res_ready=0 for 5 cycles.
  - res_data=0x0A6 is held stable and no req_ready is asserted.
  - Release res_ready with requester 3 valid (a=0xFA, b=0xC0): grant is in the same cycle as the transfer, and the next result is 0x03A.
- Assert rst for 1 cycle while in OUT: the next cycle has res_valid=0, busy=0, done_cnt=0. Then requester 1 is granted first (rr_ptr=0, no lower index valid).
- Set done_cnt to 0xFFFF by running operations (or use CNT_W=4 with 16 ops): the next accept wraps it to 0.

Source files
------------

// File: rtl/absdiff_pkg.sv
// Shared types, default sizes and the absolute-difference helper for the
// absdiff_arbiter block.
package absdiff_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_CNT_W   = 16;

    // Widest operand the helper accepts; callers zero-extend into it and
    // narrow the result back to their own DATA_W+1 bits.
    localparam int ABS_MAX_W   = 32;

    function automatic logic [ABS_MAX_W:0] abs_diff(input logic [ABS_MAX_W-1:0] a,
                                                    input logic [ABS_MAX_W-1:0] b);
        return (a > b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

endpackage

// File: rtl/absdiff_unit.sv
// Registered |a-b| with load enable and synchronous clear. The requester ID
// travels alongside so the result and its owner are always captured together.
module absdiff_unit
    import absdiff_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int ID_W   = 2,
    localparam int RES_W  = DATA_W + 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ID_W-1:0]   id,
    output logic [RES_W-1:0]  res_data,
    output logic [ID_W-1:0]   res_id
);

    // Result register: cleared by clr, otherwise captures |a-b| and ID on load.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks so every register
        // samples pre-edge values, independent of statement order.
        if (clr) begin
            res_data <= '0;
            res_id   <= '0;
        end else if (load) begin
            res_data <= RES_W'(abs_diff(ABS_MAX_W'(a), ABS_MAX_W'(b)));
            res_id   <= id;
        end
    end

endmodule

// File: rtl/absdiff_arbiter.sv
// Round-robin sharing of one registered absolute-difference unit between
// NUM_REQ requesters. Each accepted pair spends one cycle in CALC and is then
// held in OUT until the downstream side accepts it.
module absdiff_arbiter
    import absdiff_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int DATA_W  = DEF_DATA_W,
    parameter  int CNT_W   = DEF_CNT_W,
    localparam int ID_W    = $clog2(NUM_REQ),
    localparam int RES_W   = DATA_W + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [RES_W-1:0]            res_data,
    output logic [ID_W-1:0]             res_id,
    output logic                        busy,
    output logic [CNT_W-1:0]            done_cnt
);

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   idx;
    logic              found;
    logic              grant_ok;
    logic              granted;
    logic              res_xfer;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [ID_W-1:0]   op_id;

    assign res_xfer = res_valid & res_ready;
    assign busy     = (state != IDLE);

    // A grant may only be issued while idle, or while the held result leaves.
    assign grant_ok = !rst && ((state == IDLE) || ((state == OUT) && res_ready));
    assign granted  = grant_ok & found;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before the loop; a path that
        // leaves one unassigned would infer a latch.
        found  = 1'b0;
        winner = rr_ptr;
        idx    = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = rr_ptr + ID_W'(k);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Accept strobe goes to the winner only, and only in a grant cycle.
    always_comb begin
        req_ready = '0;
        if (granted) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Operand register: loaded with the winner's pair on every grant.
    always_ff @(posedge clk) begin
        // NOTE: no reset here on purpose; the operands are only consumed in
        // CALC, which is always preceded by a load.
        if (granted) begin
            op_a  <= req_a[winner*DATA_W +: DATA_W];
            op_b  <= req_b[winner*DATA_W +: DATA_W];
            op_id <= winner;
        end
    end

    // Control FSM with registered res_valid, round-robin pointer and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            res_valid <= 1'b0;
            done_cnt  <= '0;
        end else begin
            if (res_xfer) begin
                done_cnt <= done_cnt + 1'b1;
            end
            if (granted) begin
                rr_ptr <= winner + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (granted) begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    state     <= OUT;
                    res_valid <= 1'b1;
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= granted ? CALC : IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

    absdiff_unit #(
        .DATA_W (DATA_W),
        .ID_W   (ID_W)
    ) u_unit (
        .clk      (clk),
        .clr      (rst),
        .load     (state == CALC),
        .a        (op_a),
        .b        (op_b),
        .id       (op_id),
        .res_data (res_data),
        .res_id   (res_id)
    );

endmodule

// File: tb/tb_absdiff_arbiter.sv
// Scoreboard bench for absdiff_arbiter: a reference model predicts grants and
// pushes expected results; a separate monitor pops them as the DUT presents
// results. CNT_W is reduced so the completion counter wraps in a short run.
module tb_absdiff_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 4;
    localparam int ID_W    = 2;
    localparam int RES_W   = DATA_W + 1;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a = '0;
    logic [NUM_REQ*DATA_W-1:0] req_b = '0;
    logic                      res_valid;
    logic                      res_ready = 1'b1;
    logic [RES_W-1:0]          res_data;
    logic [ID_W-1:0]           res_id;
    logic                      busy;
    logic [CNT_W-1:0]          done_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int data;
        int id;
    } exp_t;

    exp_t sb[$];

    // Reference model state: whether an operation is in flight, how many
    // cycles since its grant, the round-robin start point and the count.
    bit m_busy = 1'b0;
    int m_age  = 0;
    int m_ptr  = 0;
    int m_cnt  = 0;

    always #5 clk = ~clk;

    absdiff_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic int ref_absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Reference model: predicts req_ready, res_valid, busy and done_cnt each
    // cycle, and pushes the expected result for every predicted grant.
    always @(negedge clk) begin : model_p
        int                 win;
        int                 ea;
        int                 eb;
        bit                 shown;
        logic [NUM_REQ-1:0] exp_ready;
        shown     = m_busy && (m_age >= 1);
        win       = -1;
        if (!rst && (!m_busy || (shown && res_ready))) win = pick(req_valid, m_ptr);
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("res_valid", 32'(res_valid), 32'(shown));
        check("busy", 32'(busy), 32'(m_busy));
        check("done_cnt", 32'(done_cnt), m_cnt);
        if (rst) begin
            m_busy = 1'b0;
            m_age  = 0;
            m_ptr  = 0;
            m_cnt  = 0;
            sb.delete();
        end else begin
            if (shown && res_ready) begin
                m_cnt  = (m_cnt + 1) % (1 << CNT_W);
                m_busy = 1'b0;
            end else if (m_busy) begin
                m_age++;
            end
            if (win >= 0) begin
                ea = int'(req_a[win*DATA_W +: DATA_W]);
                eb = int'(req_b[win*DATA_W +: DATA_W]);
                sb.push_back('{data: ref_absdiff(ea, eb), id: win});
                m_busy = 1'b1;
                m_age  = 0;
                m_ptr  = (win + 1) % NUM_REQ;
            end
        end
    end

    // Monitor: compares any presented result against the scoreboard head and
    // retires it when the downstream side accepts.
    always @(negedge clk) begin
        if (!rst && res_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL res_unexpected: got data 0x%0h id %0d, expected no result at %0t",
                         res_data, res_id, $time);
            end else begin
                check("res_data", 32'(res_data), sb[0].data);
                check("res_id", 32'(res_id), sb[0].id);
                if (res_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [7:0] a, input logic [7:0] b);
        req_valid[i]               = v;
        req_a[i*DATA_W +: DATA_W] = a;
        req_b[i*DATA_W +: DATA_W] = b;
    endtask

    // Hold one request until it is accepted, with a bounded wait.
    task automatic send(input int i, input logic [7:0] a, input logic [7:0] b);
        bit granted;
        granted = 1'b0;
        set_req(i, 1'b1, a, b);
        for (int c = 0; c < 50 && !granted; c++) begin
            @(negedge clk);
            granted = req_ready[i];
            @(posedge clk);
            #1;
        end
        if (!granted) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: requester %0d not granted within 50 cycles", i);
        end
        req_valid[i] = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        bit drained;
        logic [7:0] ra;
        logic [7:0] rb;
        tick(2);
        rst = 1'b0;

        // Single requesters, including equal operands and the extreme pair.
        send(0, 8'hAA, 8'h55);
        tick(4);
        send(2, 8'h0A, 8'hD5);
        tick(4);
        send(2, 8'hFA, 8'hFA);
        tick(4);
        send(3, 8'h00, 8'hFF);
        tick(4);
        send(1, 8'hFF, 8'h00);
        tick(4);

        // All four requesters held valid from a fresh pointer.
        pulse_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 8'($urandom), 8'($urandom));
        tick(16);
        req_valid = '0;
        tick(4);

        // Backpressure: result held, no grants until res_ready returns.
        res_ready = 1'b0;
        send(1, 8'hFA, 8'h54);
        tick(5);
        set_req(3, 1'b1, 8'hFA, 8'hC0);
        tick(2);
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_grant_same_cycle", 32'(req_ready), 32'h8);
        tick(1);
        req_valid = '0;
        tick(4);

        // Reset while a result is held in OUT.
        res_ready = 1'b0;
        send(0, 8'h12, 8'h34);
        tick(2);
        pulse_reset();
        res_ready = 1'b1;
        @(negedge clk);
        check("post_rst_res_valid", 32'(res_valid), 32'h0);
        check("post_rst_busy", 32'(busy), 32'h0);
        check("post_rst_done_cnt", 32'(done_cnt), 32'h0);
        tick(1);
        set_req(1, 1'b1, 8'h40, 8'h10);
        set_req(2, 1'b1, 8'h05, 8'h07);
        @(negedge clk);
        check("post_rst_first_grant", 32'(req_ready), 32'h2);
        tick(1);
        req_valid = '0;
        tick(4);

        // Enough back-to-back operations to wrap the reduced counter.
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 8'($urandom), 8'($urandom));
        tick(44);
        req_valid = '0;
        tick(4);

        // Randomized traffic with withdrawals, operand churn and backpressure.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                ra = 8'($urandom);
                rb = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom);
                set_req(i, 1'($urandom_range(0, 1)), ra, rb);
            end
            res_ready = ($urandom_range(0, 9) < 7);
            tick(1);
        end

        // Drain with a bounded wait.
        req_valid = '0;
        res_ready = 1'b1;
        drained   = 1'b0;
        for (int c = 0; c < 20 && !drained; c++) begin
            tick(1);
            drained = (sb.size() == 0) && !m_busy;
        end
        check("drain_scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
